// File: rtl/mem_bist_pkg.sv
// Shared types and constants for the memory BIST sequencer and its compare pipe.
package mem_bist_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WR_P  = 3'd1,
        RD_P  = 3'd2,
        WR_N  = 3'd3,
        RD_N  = 3'd4,
        DRAIN = 3'd5,
        DONE  = 3'd6
    } bist_state_e;

    localparam logic [7:0] ERR_MAX = 8'd255;

    // Error counter increment that sticks at ERR_MAX instead of wrapping.
    function automatic logic [7:0] sat_inc(input logic [7:0] value);
        return (value == ERR_MAX) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/mem_bist_cmp_pipe.sv
// Read-compare pipe: carries {valid, expected[, addr]} for RD_LATENCY cycles and counts mismatches.
// With MEM_BIST_ERR_LOG_EN defined it also records address/data of the first mismatch.
module mem_bist_cmp_pipe
    import mem_bist_pkg::*;
#(
    parameter int ADDR_W     = 5,
    parameter int DATA_W     = 8,
    parameter int RD_LATENCY = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clear,
    input  logic              rd_en,
    input  logic [DATA_W-1:0] exp_data,
`ifdef MEM_BIST_ERR_LOG_EN
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_data,
`endif
    input  logic [DATA_W-1:0] mem_dout,
    output logic [7:0]        err_count
);

    logic              valid_q [RD_LATENCY];
    logic [DATA_W-1:0] exp_q   [RD_LATENCY];
    logic              mismatch;

    // The tail stage lines up with the cycle in which the memory presents the read data.
    assign mismatch = valid_q[RD_LATENCY-1] && (mem_dout != exp_q[RD_LATENCY-1]);

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < RD_LATENCY; i++) begin
                valid_q[i] <= 1'b0;
            end
            err_count <= 8'd0;
        end else begin
            valid_q[0] <= rd_en;
            for (int i = 1; i < RD_LATENCY; i++) begin
                valid_q[i] <= valid_q[i-1];
            end
            if (clear) begin
                err_count <= 8'd0;
            end else if (mismatch) begin
                err_count <= sat_inc(err_count);
            end
        end
    end

    always_ff @(posedge clock) begin
        exp_q[0] <= exp_data;
        for (int i = 1; i < RD_LATENCY; i++) begin
            exp_q[i] <= exp_q[i-1];
        end
    end

`ifdef MEM_BIST_ERR_LOG_EN
    logic [ADDR_W-1:0] addr_q [RD_LATENCY];
    logic              have_fail;

    always_ff @(posedge clock) begin
        addr_q[0] <= rd_addr;
        for (int i = 1; i < RD_LATENCY; i++) begin
            addr_q[i] <= addr_q[i-1];
        end
    end

    // Only the first mismatch of a run is kept; later ones leave the log untouched.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            have_fail <= 1'b0;
            fail_addr <= '0;
            fail_data <= '0;
        end else if (mismatch && !have_fail) begin
            have_fail <= 1'b1;
            fail_addr <= addr_q[RD_LATENCY-1];
            fail_data <= mem_dout;
        end
    end
`endif

endmodule

// File: rtl/mem_bist_sequencer.sv
// March-test driver for a 2**ADDR_W x DATA_W memory: write P up, read P up, write ~P down, read ~P down.
// Define MEM_BIST_ERR_LOG_EN to add fail_addr/fail_data first-mismatch outputs.
module mem_bist_sequencer
    import mem_bist_pkg::*;
#(
    parameter int                ADDR_W     = 5,
    parameter int                DATA_W     = 8,
    parameter int                RD_LATENCY = 1,
    parameter logic [DATA_W-1:0] PATTERN    = 8'h55
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    output logic [DATA_W-1:0] mem_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rE,
    output logic              mem_wE,
    input  logic [DATA_W-1:0] mem_dout,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [7:0]        err_count,
`ifdef MEM_BIST_ERR_LOG_EN
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_data,
`endif
    output logic [2:0]        state_dbg
);

    // start is a request with no ready: it is taken only while busy=0 (IDLE or DONE);
    // a start seen while busy is dropped, never queued.

    localparam int                LAT_W    = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
    localparam logic [LAT_W-1:0]  LAT_LAST = LAT_W'(RD_LATENCY - 1);
    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

    bist_state_e       state, state_nxt;
    logic [ADDR_W-1:0] addr_cnt, addr_nxt;
    logic              rd_tail, rd_tail_nxt;
    logic [LAT_W-1:0]  lat_cnt, lat_nxt;
    logic              start_ok;
    logic              wr_en;
    logic              rd_en;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] exp_data;

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            addr_cnt <= '0;
            rd_tail  <= 1'b0;
            lat_cnt  <= '0;
        end else begin
            state    <= state_nxt;
            addr_cnt <= addr_nxt;
            rd_tail  <= rd_tail_nxt;
            lat_cnt  <= lat_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        addr_nxt    = addr_cnt;
        rd_tail_nxt = rd_tail;
        lat_nxt     = lat_cnt;
        start_ok    = 1'b0;
        wr_en       = 1'b0;
        rd_en       = 1'b0;
        wr_data     = '0;
        exp_data    = '0;

        case (state)
            IDLE, DONE: begin
                if (start) begin
                    start_ok  = 1'b1;
                    state_nxt = WR_P;
                    addr_nxt  = '0;
                end
            end

            WR_P: begin
                wr_en   = 1'b1;
                wr_data = PATTERN;
                if (addr_cnt == ADDR_MAX) begin
                    state_nxt = RD_P;
                    addr_nxt  = '0;
                end else begin
                    addr_nxt = addr_cnt + 1'b1;
                end
            end

            // After the last ascending read, RD_P idles RD_LATENCY cycles so the final
            // P compare retires before WR_N starts overwriting the array.
            RD_P: begin
                if (!rd_tail) begin
                    rd_en    = 1'b1;
                    exp_data = PATTERN;
                    if (addr_cnt == ADDR_MAX) begin
                        rd_tail_nxt = 1'b1;
                        lat_nxt     = '0;
                    end else begin
                        addr_nxt = addr_cnt + 1'b1;
                    end
                end else if (lat_cnt == LAT_LAST) begin
                    state_nxt   = WR_N;
                    rd_tail_nxt = 1'b0;
                    addr_nxt    = ADDR_MAX;
                end else begin
                    lat_nxt = lat_cnt + 1'b1;
                end
            end

            WR_N: begin
                wr_en   = 1'b1;
                wr_data = ~PATTERN;
                if (addr_cnt == '0) begin
                    state_nxt = RD_N;
                    addr_nxt  = ADDR_MAX;
                end else begin
                    addr_nxt = addr_cnt - 1'b1;
                end
            end

            RD_N: begin
                rd_en    = 1'b1;
                exp_data = ~PATTERN;
                if (addr_cnt == '0) begin
                    state_nxt = DRAIN;
                    lat_nxt   = '0;
                end else begin
                    addr_nxt = addr_cnt - 1'b1;
                end
            end

            DRAIN: begin
                if (lat_cnt == LAT_LAST) begin
                    state_nxt = DONE;
                end else begin
                    lat_nxt = lat_cnt + 1'b1;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Address and data are forced to zero whenever no access is in flight.
    assign mem_wE    = wr_en;
    assign mem_rE    = rd_en;
    assign mem_addr  = (wr_en || rd_en) ? addr_cnt : '0;
    assign mem_data  = wr_en ? wr_data : '0;

    assign busy      = (state != IDLE) && (state != DONE);
    assign done      = (state == DONE);
    assign pass      = done && (err_count == 8'd0);
    assign state_dbg = state;

    mem_bist_cmp_pipe #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .RD_LATENCY (RD_LATENCY)
    ) u_cmp_pipe (
        .clock     (clock),
        .reset     (reset),
        .clear     (start_ok),
        .rd_en     (rd_en),
        .exp_data  (exp_data),
`ifdef MEM_BIST_ERR_LOG_EN
        .rd_addr   (addr_cnt),
        .fail_addr (fail_addr),
        .fail_data (fail_data),
`endif
        .mem_dout  (mem_dout),
        .err_count (err_count)
    );

endmodule

// File: tb/tb_mem_bist_sequencer.sv
// Self-checking bench for mem_bist_sequencer: faultable memory model, op-list reference model,
// per-cycle compare process. Exercises MEM_BIST_ERR_LOG_EN outputs when that macro is defined.
module tb_mem_bist_sequencer;

    localparam int         AW      = 5;
    localparam int         DW      = 8;
    localparam int         DEPTH   = 32;
    localparam int         RUN_LEN = 130;
    localparam logic [7:0] PAT     = 8'h55;

    typedef struct packed {
        logic       re;
        logic       we;
        logic [4:0] addr;
        logic [7:0] data;
        logic [7:0] expv;
    } op_t;

    // clock / reset block
    logic clock = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    always #5 clock = ~clock;

    logic [DW-1:0] mem_data;
    logic [AW-1:0] mem_addr;
    logic          mem_rE, mem_wE;
    logic [DW-1:0] mem_dout = '0;
    logic          busy, done, pass;
    logic [7:0]    err_count;
    logic [2:0]    state_dbg;
`ifdef MEM_BIST_ERR_LOG_EN
    logic [AW-1:0] fail_addr;
    logic [DW-1:0] fail_data;
`endif

    mem_bist_sequencer dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .mem_data  (mem_data),
        .mem_addr  (mem_addr),
        .mem_rE    (mem_rE),
        .mem_wE    (mem_wE),
        .mem_dout  (mem_dout),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .err_count (err_count),
`ifdef MEM_BIST_ERR_LOG_EN
        .fail_addr (fail_addr),
        .fail_data (fail_data),
`endif
        .state_dbg (state_dbg)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Faultable memory: per-cell stuck-at-0/1 masks on write, read-as-zero cells.
    logic [7:0] cells [DEPTH];
    logic [7:0] s0    [DEPTH];
    logic [7:0] s1    [DEPTH];
    logic       rz    [DEPTH];

    function automatic logic [7:0] store_val(input int a, input logic [7:0] d);
        return (d & ~s0[a]) | s1[a];
    endfunction

    function automatic logic [7:0] load_val(input int a, input logic [7:0] v);
        return rz[a] ? 8'h00 : v;
    endfunction

    always @(posedge clock) begin
        if (mem_wE) cells[mem_addr] <= store_val(int'(mem_addr), mem_data);
        if (mem_rE) mem_dout <= load_val(int'(mem_addr), cells[mem_addr]);
    end

    task automatic clear_faults();
        for (int i = 0; i < DEPTH; i++) begin
            s0[i] = 8'h00;
            s1[i] = 8'h00;
            rz[i] = 1'b0;
        end
    endtask

    // Reference model: the expected bus activity of one run as a list of per-cycle ops.
    op_t ops[$];

    function automatic op_t mk(input logic re, input logic we, input int a, input logic [7:0] d,
                               input logic [7:0] e);
        op_t o;
        o.re   = re;
        o.we   = we;
        o.addr = 5'(a);
        o.data = d;
        o.expv = e;
        return o;
    endfunction

    task automatic build_ops();
        ops.delete();
        for (int a = 0; a < DEPTH; a++) ops.push_back(mk(1'b0, 1'b1, a, PAT, 8'h00));
        for (int a = 0; a < DEPTH; a++) ops.push_back(mk(1'b1, 1'b0, a, 8'h00, PAT));
        ops.push_back(mk(1'b0, 1'b0, 0, 8'h00, 8'h00));
        for (int a = DEPTH - 1; a >= 0; a--) ops.push_back(mk(1'b0, 1'b1, a, ~PAT, 8'h00));
        for (int a = DEPTH - 1; a >= 0; a--) ops.push_back(mk(1'b1, 1'b0, a, 8'h00, ~PAT));
        ops.push_back(mk(1'b0, 1'b0, 0, 8'h00, 8'h00));
    endtask

    // Plays the op list against a private memory image and counts read mismatches.
    function automatic int predict_errors();
        logic [7:0] img [DEPTH];
        int n = 0;
        foreach (ops[i]) begin
            if (ops[i].we) img[ops[i].addr] = store_val(int'(ops[i].addr), ops[i].data);
            if (ops[i].re && load_val(int'(ops[i].addr), img[ops[i].addr]) != ops[i].expv) n++;
        end
        return (n > 255) ? 255 : n;
    endfunction

    // m_pos: -1 idle/after reset, -2 done, 0..RUN_LEN-1 position within a run.
    int         m_pos = -1;
    logic [7:0] m_err = 8'd0;
    logic       chk_en = 1'b0;

    always @(posedge clock) begin
        if (reset) begin
            m_pos = -1;
            m_err = 8'd0;
        end else if (m_pos < 0) begin
            if (start) begin
                m_pos = 0;
                m_err = 8'(predict_errors());
            end
        end else if (m_pos == RUN_LEN - 1) begin
            m_pos = -2;
        end else begin
            m_pos++;
        end
    end

    // Scoreboard: every cycle, expected bus/control values come from the model position.
    logic [31:0] exp_q[$];
    always @(negedge clock) begin
        op_t  e;
        logic eb, ed, ep;
        if (chk_en) begin
            if (m_pos >= 0) begin
                e  = ops[m_pos];
                eb = 1'b1;
                ed = 1'b0;
                ep = 1'b0;
            end else begin
                e  = '0;
                eb = 1'b0;
                ed = (m_pos == -2);
                ep = ed && (m_err == 8'd0);
            end
            exp_q.push_back({16'd0, e.re, e.we, e.addr, e.data});
            check("mem_bus", {16'd0, mem_rE, mem_wE, mem_addr, mem_data}, exp_q.pop_front());
            check("ctrl", {29'd0, busy, done, pass}, {29'd0, eb, ed, ep});
            if (m_pos < 0) check("err_count", {24'd0, err_count}, {24'd0, m_err});
        end
    end

    int busy_cur  = 0;
    int busy_last = 0;
    always @(negedge clock) begin
        if (busy) busy_cur++;
        else if (busy_cur != 0) begin
            busy_last = busy_cur;
            busy_cur  = 0;
        end
    end

    // driver tasks
    task automatic pulse_start();
        @(posedge clock); #1 start = 1'b1;
        @(posedge clock); #1 start = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 300; i++) begin
            @(negedge clock);
            if (done) break;
        end
        check("done_seen", {31'd0, done}, 32'd1);
        @(negedge clock);
    endtask

    task automatic run_and_check(input string tag, input int exp_err);
        check({tag, "_model"}, 32'(predict_errors()), 32'(exp_err));
        pulse_start();
        wait_done();
        check({tag, "_len"}, 32'(busy_last), 32'(RUN_LEN));
        check({tag, "_err"}, {24'd0, err_count}, 32'(exp_err));
        check({tag, "_pass"}, {31'd0, pass}, {31'd0, (exp_err == 0)});
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) cells[i] = 8'h00;
        clear_faults();
        build_ops();
        @(posedge clock); #1 chk_en = 1'b1;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_err", {24'd0, err_count}, 32'd0);

        run_and_check("ideal", 0);

        clear_faults();
        s0[5] = 8'h01;
        run_and_check("stuck_a5b0", 1);
`ifdef MEM_BIST_ERR_LOG_EN
        check("log_a5_addr", {27'd0, fail_addr}, 32'd5);
        check("log_a5_data", {24'd0, fail_data}, 32'h54);
`endif

        clear_faults();
        for (int a = 8; a < 16; a++) rz[a] = 1'b1;
        run_and_check("chip1_dead", 16);

        clear_faults();
        for (int a = 0; a < DEPTH; a++) rz[a] = 1'b1;
        for (int r = 0; r < 3; r++) run_and_check("all_zero", 64);

        // Reset during the ascending-read phase, then a clean full run.
        clear_faults();
        pulse_start();
        repeat (39) @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock); #1 reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check("post_rst_we", {30'd0, mem_wE, busy}, 32'd0);
        end
        run_and_check("after_rst", 0);

        // start pulses while busy must not disturb the run.
        clear_faults();
        s0[9] = 8'h01;
        check("noise_model", 32'(predict_errors()), 32'd1);
        pulse_start();
        for (int i = 0; i < 100; i++) begin
            @(posedge clock); #1 start = ($urandom_range(0, 7) == 0);
        end
        @(posedge clock); #1 start = 1'b0;
        wait_done();
        check("noise_len", 32'(busy_last), 32'(RUN_LEN));
        check("noise_err", {24'd0, err_count}, 32'd1);
`ifdef MEM_BIST_ERR_LOG_EN
        check("log_a9_addr", {27'd0, fail_addr}, 32'd9);
`endif

        // Random stuck-at faults: expectations come from the model only.
        for (int r = 0; r < 6; r++) begin
            clear_faults();
            for (int k = 0; k < int'($urandom_range(1, 5)); k++) begin
                int a;
                a = int'($urandom_range(0, DEPTH - 1));
                s0[a] = 8'($urandom_range(0, 255));
                s1[a] = 8'($urandom_range(0, 255)) & 8'($urandom_range(0, 255));
                rz[a] = ($urandom_range(0, 5) == 0);
            end
            pulse_start();
            wait_done();
            check("rand_len", 32'(busy_last), 32'(RUN_LEN));
        end

        repeat (3) @(negedge clock);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
